rwt_adc_if_regs: RTL
====================

Name: rwt_adc_if_regs

Overview:
Parametrised control and status register bank for the multi-channel ADC/user/DMA interface.
- Replaces the fixed three-register decode with a configurable map: per-channel enable mask, ESCAPE_WIDTH-bit tag escape with shadow/commit semantics, per-channel sticky overflow status (W1C), saturating overflow counters, IRQ output.
- All logic is in the up_clk domain. Consumers in other domains synchronise the outputs; producers deliver ovf_pulse already synchronised to up_clk.

Parameters:
NUM_CHANNELS, 4, number of ADC channels (1..8).
ESCAPE_WIDTH, 64, tag escape width; multiple of 32, 32..128; NW = ESCAPE_WIDTH/32.
CNT_WIDTH, 16, overflow counter width (1..32).
ESCAPE_RESET_WORD, 32'hAAAAAAAA, reset value replicated into every escape word.

Ports:
up_clk  in  1  register clock
up_rstn  in  1  reset, asynchronous, active-low
up_wreq  in  1  write request, single-cycle
up_waddr  in  9  write word address
up_wdata  in  32  write data
up_wack  out  1  write acknowledge
up_rreq  in  1  read request, single-cycle
up_raddr  in  9  read word address
up_rdata  out  32  read data
up_rack  out  1  read acknowledge
ovf_pulse  in  NUM_CHANNELS  per-channel overflow event, 1-cycle pulse, up_clk domain
use_tags  out  1  tag insertion enable
chan_mask  out  NUM_CHANNELS  channel enable mask
tag_escape  out  ESCAPE_WIDTH  active escape value; word 0 in MSBs
escape_update  out  1  1-cycle pulse when tag_escape changes
irq  out  1  interrupt, level

Behaviour:
- Reset values (async on up_rstn low):
  - up_wack = up_rack = 0; up_rdata = 0.
  - use_tags = 0; chan_mask = all ones.
  - STATUS = 0; IRQ_EN = 0; counters = 0.
  - Shadow and active escape = ESCAPE_RESET_WORD in every word; escape_update = 0; irq = 0.
- Handshake:
  - up_wack = up_wreq delayed 1 cycle; up_rack = up_rreq delayed 1 cycle.
  - up_rdata is updated only when up_rreq = 1, is valid in the up_rack cycle, and holds otherwise.
  - Unmapped reads return 0. Unmapped writes are acked and ignored.
  - wreq and rreq may coincide. A read of the address being written in the same cycle returns the pre-write value.
- Register map (word addresses):
  - 0x00 CTRL RW: bit0 use_tags; bits[8 +: NUM_CHANNELS] chan_mask; other bits read 0.
  - 0x01 STATUS W1C: bit i is sticky overflow for channel i. If ovf_pulse[i] and a W1C of bit i occur in the same cycle, the bit stays 1 (set wins).
  - 0x02 IRQ_EN RW: bits[NUM_CHANNELS-1:0].
  - 0x03 COMMIT WO: any write copies the shadow escape to tag_escape on the next edge and asserts escape_update for exactly that 1 cycle; reads return 0.
  - 0x04 ID RO: {8'(NUM_CHANNELS), 8'(NW), 16'h0002}.
  - 0x08+k ESCAPE shadow word k, RW, k < NW. Reads return the shadow, not the active value. Writing the shadow never changes tag_escape.
  - 0x20+i COUNT channel i, i < NUM_CHANNELS:
    - Reads are zero-extended.
    - Any write clears the counter.
    - Increments on ovf_pulse[i] and saturates at 2^CNT_WIDTH-1 (no wrap).
    - Clear and pulse in the same cycle → counter = 1.
    - A read in a pulse cycle returns the pre-increment value.
- irq = |(STATUS & IRQ_EN), decoded from registered state; it asserts the cycle after a STATUS bit sets, if enabled.
- Reset mid-operation: all state returns to reset values immediately. An outstanding ack is dropped, and no escape_update is emitted.

Test Plan:
- Reset → read 0x00 = 0x00000F00, 0x04 = 0x04020002, 0x08 and 0x09 = 0xAAAAAAAA; tag_escape = 64'hAAAA_AAAA_AAAA_AAAA; each ack 1 cycle after its req.
- Write 0x08 = 0x12345678, 0x09 = 0x9ABCDEF0 → tag_escape unchanged. Then write 0x03 → tag_escape = 64'h12345678_9ABCDEF0 next cycle, escape_update high exactly 1 cycle.
- Pulse ovf_pulse[2] three times with IRQ_EN = 0x4 → STATUS = 0x4, COUNT 0x22 = 3, irq = 1. Write 0x01 = 0x4 → STATUS 0, irq 0.
- W1C of bit 1 in the same cycle as ovf_pulse[1] → STATUS bit1 stays 1. Write 0x21 in the same cycle as a pulse → COUNT = 1.
- CNT_WIDTH = 4, 20 pulses on channel 0 → COUNT 0x20 = 15.
- Assert up_rstn low mid-read after escape commit → up_rack 0, tag_escape back to 0xAA pattern; read of 0x30 (unmapped) returns 0 with ack.

Source files
------------

// File: rtl/rwt_adc_if_regs_if.sv
// rtl/rwt_adc_if_regs_if.sv - register request/ack bus between host and rwt_adc_if_regs
interface rwt_adc_if_regs_if;
  logic        up_wreq;
  logic [8:0]  up_waddr;
  logic [31:0] up_wdata;
  logic        up_wack;
  logic        up_rreq;
  logic [8:0]  up_raddr;
  logic [31:0] up_rdata;
  logic        up_rack;

  modport master (
    output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    input  up_wack, up_rdata, up_rack
  );

  modport slave (
    input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    output up_wack, up_rdata, up_rack
  );
endinterface

// File: rtl/rwt_adc_if_regs.sv
// rtl/rwt_adc_if_regs.sv - control/status register bank for the multi-channel ADC interface
module rwt_adc_if_regs #(
  parameter int          NUM_CHANNELS      = 4,
  parameter int          ESCAPE_WIDTH      = 64,
  parameter int          CNT_WIDTH         = 16,
  parameter logic [31:0] ESCAPE_RESET_WORD = 32'hAAAAAAAA
) (
  input  logic                    up_clk,
  input  logic                    up_rstn,
  rwt_adc_if_regs_if.slave        up_bus,
  input  logic [NUM_CHANNELS-1:0] ovf_pulse,
  output logic                    use_tags,
  output logic [NUM_CHANNELS-1:0] chan_mask,
  output logic [ESCAPE_WIDTH-1:0] tag_escape,
  output logic                    escape_update,
  output logic                    irq
);

  localparam int                    NW        = ESCAPE_WIDTH / 32;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [ESCAPE_WIDTH-1:0] ESC_RESET = {NW{ESCAPE_RESET_WORD}};

  logic                                   wack_q, wack_d;
  logic                                   rack_q, rack_d;
  logic [31:0]                            rdata_q, rdata_d;
  logic                                   use_tags_q, use_tags_d;
  logic [NUM_CHANNELS-1:0]                chan_mask_q, chan_mask_d;
  logic [NUM_CHANNELS-1:0]                status_q, status_d;
  logic [NUM_CHANNELS-1:0]                irq_en_q, irq_en_d;
  logic [ESCAPE_WIDTH-1:0]                shadow_q, shadow_d;
  logic [ESCAPE_WIDTH-1:0]                tag_escape_q, tag_escape_d;
  logic                                   escape_update_q, escape_update_d;
  logic [NUM_CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CHANNELS-1:0]                status_clr;
  logic [31:0]                            rd_val;

  // Control, status, shadow/commit escape and handshake next-state decode
  always_comb begin
    wack_d          = up_bus.up_wreq;
    rack_d          = up_bus.up_rreq;
    use_tags_d      = use_tags_q;
    chan_mask_d     = chan_mask_q;
    irq_en_d        = irq_en_q;
    shadow_d        = shadow_q;
    tag_escape_d    = tag_escape_q;
    escape_update_d = 1'b0;
    status_clr      = '0;
    if (up_bus.up_wreq) begin
      if (up_bus.up_waddr == 9'h000) begin
        use_tags_d  = up_bus.up_wdata[0];
        chan_mask_d = up_bus.up_wdata[8 +: NUM_CHANNELS];
      end
      if (up_bus.up_waddr == 9'h001) status_clr = up_bus.up_wdata[NUM_CHANNELS-1:0];
      if (up_bus.up_waddr == 9'h002) irq_en_d = up_bus.up_wdata[NUM_CHANNELS-1:0];
      if (up_bus.up_waddr == 9'h003) begin
        tag_escape_d    = shadow_q;
        escape_update_d = 1'b1;
      end
      for (int k = 0; k < NW; k++) begin
        if (up_bus.up_waddr == 9'(8 + k)) shadow_d[ESCAPE_WIDTH-1-32*k -: 32] = up_bus.up_wdata;
      end
    end
    // A new overflow beats a same-cycle clear so no event is ever lost
    status_d = (status_q & ~status_clr) | ovf_pulse;
  end

  // Saturating per-channel overflow counters; a write clears, a coincident pulse counts as one
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (up_bus.up_wreq && up_bus.up_waddr == 9'(32 + i)) begin
        cnt_d[i] = ovf_pulse[i] ? CNT_WIDTH'(1) : '0;
      end else if (ovf_pulse[i] && cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Read mux from current (pre-write) state; data is captured only on a read request
  always_comb begin
    rd_val = '0;
    if (up_bus.up_raddr == 9'h000) begin
      rd_val[0]                 = use_tags_q;
      rd_val[8 +: NUM_CHANNELS] = chan_mask_q;
    end
    if (up_bus.up_raddr == 9'h001) rd_val[NUM_CHANNELS-1:0] = status_q;
    if (up_bus.up_raddr == 9'h002) rd_val[NUM_CHANNELS-1:0] = irq_en_q;
    if (up_bus.up_raddr == 9'h004) rd_val = {8'(NUM_CHANNELS), 8'(NW), 16'h0002};
    for (int k = 0; k < NW; k++) begin
      if (up_bus.up_raddr == 9'(8 + k)) rd_val = shadow_q[ESCAPE_WIDTH-1-32*k -: 32];
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (up_bus.up_raddr == 9'(32 + i)) rd_val[CNT_WIDTH-1:0] = cnt_q[i];
    end
    rdata_d = up_bus.up_rreq ? rd_val : rdata_q;
  end

  // State registers; asynchronous reset drops pending acks and escape_update
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      wack_q          <= 1'b0;
      rack_q          <= 1'b0;
      rdata_q         <= '0;
      use_tags_q      <= 1'b0;
      chan_mask_q     <= '1;
      status_q        <= '0;
      irq_en_q        <= '0;
      shadow_q        <= ESC_RESET;
      tag_escape_q    <= ESC_RESET;
      escape_update_q <= 1'b0;
      cnt_q           <= '0;
    end else begin
      wack_q          <= wack_d;
      rack_q          <= rack_d;
      rdata_q         <= rdata_d;
      use_tags_q      <= use_tags_d;
      chan_mask_q     <= chan_mask_d;
      status_q        <= status_d;
      irq_en_q        <= irq_en_d;
      shadow_q        <= shadow_d;
      tag_escape_q    <= tag_escape_d;
      escape_update_q <= escape_update_d;
      cnt_q           <= cnt_d;
    end
  end

  assign up_bus.up_wack  = wack_q;
  assign up_bus.up_rack  = rack_q;
  assign up_bus.up_rdata = rdata_q;
  assign use_tags        = use_tags_q;
  assign chan_mask       = chan_mask_q;
  assign tag_escape      = tag_escape_q;
  assign escape_update   = escape_update_q;
  assign irq             = |(status_q & irq_en_q);

endmodule
